pe_acc: RTL and testbench

PE_ACC -- requirements
Module: pe_acc

---
 rtl/pe_acc.sv | 110 +++++++++++
 tb/tb_pe_acc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pe_acc.sv
// Processing-element accumulator: reduces 32 int32 products per beat into a
// single signed job sum through a two-stage adder pipeline.
//
// state | meaning
// IDLE  | waiting for acc_start with a non-zero acc_len
// ACC   | accepting product beats until beats_left runs out
// DRAIN | two cycles letting the last beat settle into the accumulator
// DONE  | acc_result valid, waiting for out_ready
module pe_acc (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          acc_start,
    input  logic [7:0]    acc_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] mult_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   acc_result,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  beats_left;
    logic        drain_cnt;
    logic [31:0] lane_sum [4];
    logic [31:0] part     [4];
    logic        s1_valid;
    logic [31:0] acc;
    logic [31:0] acc_res_q;
    logic        accept;
    logic        start_ok;

    assign accept     = in_valid && (state == ACC);
    assign start_ok   = (state == IDLE) && acc_start && (acc_len != 8'd0);
    assign acc_result = acc_res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACC;
            ACC:     if (accept && beats_left == 8'd1) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            ACC:     in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Each partial covers lanes 8k..8k+7; sums wrap modulo 2^32.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_sum[k] = 32'd0;
            for (int j = 0; j < 8; j++) begin
                lane_sum[k] = lane_sum[k] + mult_result[(8*k + j)*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= 8'd0;
            drain_cnt  <= 1'b0;
            s1_valid   <= 1'b0;
            acc        <= 32'd0;
            acc_res_q  <= 32'd0;
            for (int k = 0; k < 4; k++) part[k] <= 32'd0;
        end else begin
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            s1_valid  <= accept;
            if (accept) begin
                beats_left <= beats_left - 8'd1;
                for (int k = 0; k < 4; k++) part[k] <= lane_sum[k];
            end
            if (start_ok) begin
                beats_left <= acc_len;
                acc        <= 32'd0;
            end else if (s1_valid) begin
                acc <= acc + part[0] + part[1] + part[2] + part[3];
            end
            // The last beat landed in acc one edge earlier, so acc is final here.
            if (state == DRAIN && drain_cnt) begin
                acc_res_q <= acc;
            end
        end
    end

endmodule

// File: tb/tb_pe_acc.sv
// Directed-vector bench for pe_acc; inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_pe_acc;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acc_start;
    logic [7:0]    acc_len;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] mult_result;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   acc_result;
    logic          busy;

    int errors = 0;
    int checks = 0;

    pe_acc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_start  (acc_start),
        .acc_len    (acc_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mult_result(mult_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_result (acc_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] splat(input logic [31:0] v);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    task automatic start_job(input logic [7:0] len);
        acc_start = 1'b1;
        acc_len   = len;
        step();
        acc_start = 1'b0;
    endtask

    task automatic beat(input logic [1023:0] data);
        in_valid    = 1'b1;
        mult_result = data;
        step();
        in_valid    = 1'b0;
    endtask

    initial begin
        logic [1023:0] ramp;
        rst_n       = 1'b0;
        acc_start   = 1'b0;
        acc_len     = 8'd0;
        in_valid    = 1'b0;
        mult_result = '0;
        out_ready   = 1'b1;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", acc_result, 32'd0);
        rst_n = 1'b1;
        step();

        // Single beat of all ones: 32 lanes * 1.
        start_job(8'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        beat(splat(32'd1));
        chk("t1_drain_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_e1_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_e2_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_e3_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_result", acc_result, 32'd32);
        step();
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // Four beats of -1 with a two-cycle gap: 4 * 32 * -1 = -128.
        start_job(8'd4);
        beat(splat(32'hFFFF_FFFF));
        beat(splat(32'hFFFF_FFFF));
        step();
        chk("t2_gap_ready", {31'd0, in_ready}, 32'd1);
        step();
        beat(splat(32'hFFFF_FFFF));
        chk("t2_third_ready", {31'd0, in_ready}, 32'd1);
        beat(splat(32'hFFFF_FFFF));
        chk("t2_after_last_ready", {31'd0, in_ready}, 32'd0);
        step();
        step();
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_result", acc_result, 32'hFFFF_FF80);
        step();

        // Two lanes of INT_MAX wrap to -2.
        start_job(8'd1);
        mult_result = '0;
        mult_result[31:0]  = 32'h7FFF_FFFF;
        mult_result[63:32] = 32'h7FFF_FFFF;
        beat(mult_result);
        step();
        step();
        chk("t3_result", acc_result, 32'hFFFF_FFFE);
        step();

        // Back-pressure in DONE: ramp lanes 0..31 sum to 496.
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) ramp[i*32 +: 32] = i;
        start_job(8'd1);
        beat(ramp);
        step();
        step();
        acc_start = 1'b1;
        acc_len   = 8'd3;
        for (int c = 0; c < 5; c++) begin
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_result", acc_result, 32'd496);
            step();
        end
        out_ready = 1'b1;
        step();
        acc_start = 1'b0;
        chk("t4_exit_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_exit_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t4_start_ignored", {31'd0, busy}, 32'd0);

        // Zero-length start is ignored.
        start_job(8'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd0);

        // Mid-job asynchronous reset, then a fresh job.
        start_job(8'd4);
        beat(splat(32'd5));
        beat(splat(32'd5));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_result", acc_result, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("t6_post_rst_idle", {31'd0, busy}, 32'd0);
        beat(splat(32'd9));
        chk("t6_idle_beat_ignored", {31'd0, busy}, 32'd0);
        start_job(8'd1);
        beat(splat(32'd2));
        step();
        step();
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_result", acc_result, 32'd64);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
